sipo_frame_controller: RTL

//  Sequences an 8-bit serial-in/parallel-out capture path: frames serial bits, counts them into a

---
 rtl/sipo_frame_controller_if.sv | 41 ++++
 rtl/sipo_frame_controller.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sipo_frame_controller_if.sv
// sipo_frame_controller_if
//   Bundles the serial input, the parallel valid/ready output and the status flags
//   of sipo_frame_controller.
//   slave  : the controller side (serial/handshake inputs in, word and status out)
//   master : the environment side (serial source plus word consumer)
//   Parity_Error_Out exists only when SIPO_PARITY_CHECK_EN is defined.
interface sipo_frame_controller_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic                  Frame_Start_In;
  logic                  Serial_Data_In;
  logic                  Serial_Valid_In;
  logic                  Data_Ready_In;
  logic                  Overrun_Clear_In;
  logic [DATA_WIDTH-1:0] Parallel_Data_Out;
  logic                  Data_Valid_Out;
  logic                  Busy_Out;
  logic [CW-1:0]         Bit_Count_Out;
  logic                  Overrun_Out;
`ifdef SIPO_PARITY_CHECK_EN
  logic                  Parity_Error_Out;
`endif

  modport slave (
    input  Frame_Start_In, Serial_Data_In, Serial_Valid_In, Data_Ready_In, Overrun_Clear_In,
    output Parallel_Data_Out, Data_Valid_Out, Busy_Out, Bit_Count_Out, Overrun_Out
`ifdef SIPO_PARITY_CHECK_EN
    , output Parity_Error_Out
`endif
  );

  modport master (
    output Frame_Start_In, Serial_Data_In, Serial_Valid_In, Data_Ready_In, Overrun_Clear_In,
    input  Parallel_Data_Out, Data_Valid_Out, Busy_Out, Bit_Count_Out, Overrun_Out
`ifdef SIPO_PARITY_CHECK_EN
    , input Parity_Error_Out
`endif
  );
endinterface

// File: rtl/sipo_frame_controller.sv
// sipo_frame_controller
//   Frames a serial bit stream into DATA_WIDTH-bit words (LSB = first bit received)
//   and offers each completed word from a holding register on a valid/ready handshake.
//   Optional feature macro: SIPO_PARITY_CHECK_EN -- a parity bit follows each word and
//   Parity_Error_Out reports its check (PARITY_ODD selects odd/even parity).
// Ports
//   Clk_In    : clock, rising edge
//   Reset_In  : asynchronous active-high reset
//   bus       : sipo_frame_controller_if.slave (serial input, word handshake, status)
module sipo_frame_controller #(
  parameter int DATA_WIDTH = 8
`ifdef SIPO_PARITY_CHECK_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                     Clk_In,
  input  logic                     Reset_In,
  sipo_frame_controller_if.slave   bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

`ifdef SIPO_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t                state_reg, state_next;
  logic [CW-1:0]         count_reg, count_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  valid_reg;
  logic                  overrun_reg;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] xfer_word;
  logic [DATA_WIDTH-1:0] shifted;
`ifdef SIPO_PARITY_CHECK_EN
  logic                  parity_err_reg;
`endif

  assign shifted = {bus.Serial_Data_In, shift_reg[DATA_WIDTH-1:1]};

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_reg <= IDLE;
      count_reg <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    shift_next = shift_reg;
    xfer       = 1'b0;
    xfer_word  = shifted;
    case (state_reg)
      IDLE: begin
        if (bus.Frame_Start_In) begin
          state_next = SHIFT;
          count_next = '0;
        end
      end
      SHIFT: begin
        // A frame start beats a coincident strobe: the bit is dropped, shift_reg kept.
        if (bus.Frame_Start_In) begin
          count_next = '0;
        end else if (bus.Serial_Valid_In) begin
          shift_next = shifted;
          if (count_reg == LAST_BIT) begin
`ifdef SIPO_PARITY_CHECK_EN
            state_next = PARITY;
            count_next = CW'(DATA_WIDTH);
`else
            xfer       = 1'b1;
            state_next = IDLE;
            count_next = '0;
`endif
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end
`ifdef SIPO_PARITY_CHECK_EN
      PARITY: begin
        // The word is already complete in shift_reg; this strobe carries the parity bit.
        xfer_word = shift_reg;
        if (bus.Frame_Start_In) begin
          state_next = SHIFT;
          count_next = '0;
        end else if (bus.Serial_Valid_In) begin
          xfer       = 1'b1;
          state_next = IDLE;
          count_next = '0;
        end
      end
`endif
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // Holding register and handshake. A completed word is dropped only when the held
  // word is still valid and not being consumed on this same edge.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      parity_err_reg <= 1'b0;
`endif
    end else begin
      if (bus.Overrun_Clear_In) begin
        overrun_reg <= 1'b0;
      end
      if (xfer) begin
        if (valid_reg && !bus.Data_Ready_In) begin
          overrun_reg <= 1'b1;  // later assignment: set beats a coincident clear
        end else begin
          data_reg  <= xfer_word;
          valid_reg <= 1'b1;
        end
`ifdef SIPO_PARITY_CHECK_EN
        parity_err_reg <= ((^xfer_word) ^ bus.Serial_Data_In) != PARITY_ODD;
`endif
      end else if (valid_reg && bus.Data_Ready_In) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign bus.Parallel_Data_Out = data_reg;
  assign bus.Data_Valid_Out    = valid_reg;
  assign bus.Busy_Out          = (state_reg != IDLE);
  assign bus.Bit_Count_Out     = count_reg;
  assign bus.Overrun_Out       = overrun_reg;
`ifdef SIPO_PARITY_CHECK_EN
  assign bus.Parity_Error_Out  = parity_err_reg;
`endif
endmodule
